// File: rtl/mips_cpu_muldiv_pkg.sv
// Shared types and constants for the iterative MIPS multiply/divide unit.
// Contents: operation and FSM state enums, datapath widths, iteration count,
// and a magnitude helper used when latching signed operands.
package mips_cpu_muldiv_pkg;

    localparam int unsigned MULDIV_W     = 32;
    localparam int unsigned MULDIV_DW    = 2 * MULDIV_W;
    localparam int unsigned MULDIV_ITER  = 32;
    localparam int unsigned MULDIV_CNT_W = $clog2(MULDIV_ITER);

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } muldiv_state_t;

    // Two's-complement magnitude; 32'h8000_0000 maps to itself, which is the
    // correct unsigned magnitude for the iterative datapath.
    function automatic logic [MULDIV_W-1:0] abs_w(input logic [MULDIV_W-1:0] x);
        return x[MULDIV_W-1] ? -x : x;
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit; sole writer of the HI/LO registers.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset
//   start          request, accepted in IDLE or DONE
//   op[1:0]        MULT/MULTU/DIV/DIVU, sampled with start
//   a[31:0]        multiplicand / dividend, sampled with start
//   b[31:0]        multiplier / divisor, sampled with start
//   busy           operation in progress (CALC, FIX)
//   done           one-cycle pulse, HI/LO write-enable
//   hi_out[31:0]   product[63:32] or remainder
//   lo_out[31:0]   product[31:0] or quotient
// Fixed 33-cycle latency from the accepting edge to done for every op.
module mips_cpu_muldiv
    import mips_cpu_muldiv_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [MULDIV_W-1:0] a,
    input  logic [MULDIV_W-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [MULDIV_W-1:0] hi_out,
    output logic [MULDIV_W-1:0] lo_out
);

    localparam int unsigned W = MULDIV_W;

    muldiv_state_t           state_q, state_d;
    muldiv_op_t              op_q, op_d;
    logic [W-1:0]            opnd_q, opnd_d;
    logic [MULDIV_DW-1:0]    acc_q, acc_d;
    logic [MULDIV_CNT_W-1:0] cnt_q, cnt_d;
    logic                    neg_res_q, neg_res_d;
    logic                    neg_rem_q, neg_rem_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [W-1:0]            hi_q, hi_d;
    logic [W-1:0]            lo_q, lo_d;

    logic                    accept;
    logic                    sgn_in;
    logic                    is_div;
    logic [W-1:0]            a_mag, b_mag;
    logic [W:0]              mul_sum, div_diff;
    logic [W-1:0]            quot, rem;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign sgn_in = ~op[0];
    assign is_div = (op_q == DIV) || (op_q == DIVU);
    assign a_mag  = sgn_in ? abs_w(a) : a;
    assign b_mag  = sgn_in ? abs_w(b) : b;

    // Multiply step: conditionally add the multiplicand into the upper half
    // (carry kept in bit W), then shift the whole accumulator right.
    assign mul_sum  = {1'b0, acc_q[MULDIV_DW-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Divide step: trial-subtract the divisor from the left-shifted remainder.
    assign div_diff = acc_q[MULDIV_DW-1:W-1] - {1'b0, opnd_q};
    assign quot     = acc_q[W-1:0];
    assign rem      = acc_q[MULDIV_DW-1:W];

    // State register and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (cnt_q == MULDIV_CNT_W'(MULDIV_ITER - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so busy/done come straight from flops.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            CALC, FIX: busy_d = 1'b1;
            DONE:      done_d = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next-state: operand latch, iteration, sign fix-up.
    always_comb begin
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (accept) begin
            op_d      = muldiv_op_t'(op);
            neg_res_d = sgn_in & (a[W-1] ^ b[W-1]);
            neg_rem_d = sgn_in & a[W-1];
            cnt_d     = '0;
            // Divide keeps the divisor in opnd and the dividend in the low
            // half; multiply keeps the multiplicand in opnd, multiplier low.
            if (op[1]) begin
                opnd_d = b_mag;
                acc_d  = {{W{1'b0}}, a_mag};
            end else begin
                opnd_d = a_mag;
                acc_d  = {{W{1'b0}}, b_mag};
            end
        end else begin
            case (state_q)
                CALC: begin
                    cnt_d = cnt_q + MULDIV_CNT_W'(1);
                    if (is_div) begin
                        acc_d = div_diff[W] ? {acc_q[MULDIV_DW-2:0], 1'b0}
                                            : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
                    end else begin
                        acc_d = {mul_sum, acc_q[W-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        // Zero divisor yields all-ones quotient; the remainder
                        // path already reproduces the original dividend.
                        lo_d = (opnd_q == '0) ? '1 : (neg_res_q ? -quot : quot);
                        hi_d = neg_rem_q ? -rem : rem;
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= MULT;
            opnd_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule
